// File: rtl/elev_pkg.sv
// Shared types and constants for the elevator scheduler.
// State encoding, engine codes and travel direction values.
package elev_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVING    = 2'd1,
      DOOR_OPEN = 2'd2
   } state_e;

   localparam logic [1:0] ENG_OFF  = 2'b00;
   localparam logic [1:0] ENG_UP   = 2'b10;
   localparam logic [1:0] ENG_DOWN = 2'b11;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   function automatic logic [1:0] eng_code(input logic dir);
      return dir ? ENG_UP : ENG_DOWN;
   endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter shared by floor travel and door dwell timing.
// Load wins over hold; the count saturates at zero.
module elev_timer #(
   parameter int W = 3
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_value_i,
   input  logic         hold_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_value_i;
      else if (!hold_i && cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-ordered elevator request scheduler and car sequencer.
// Define ELEV_DOOR_HOLD_EN to add the door_hold input.
module elevator_scheduler
   import elev_pkg::*;
#(
   parameter int NUM_FLOORS    = 3,
   parameter int TRAVEL_CYCLES = 8,
   parameter int DOOR_CYCLES   = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
`ifdef ELEV_DOOR_HOLD_EN
   input  logic                          door_hold,
`endif
   input  logic [NUM_FLOORS-1:0]         interior_panel,
   input  logic [NUM_FLOORS-1:0]         exterior_panel,
   output logic [1:0]                    engine,
   output logic [NUM_FLOORS-1:0]         doors,
   output logic [$clog2(NUM_FLOORS)-1:0] current_floor,
   output logic [NUM_FLOORS-1:0]         pending,
   output logic                          direction,
   output logic                          busy
);

   localparam int FW   = $clog2(NUM_FLOORS);
   localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ?
                         TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int TW   = $clog2(TMAX);

   localparam logic [TW-1:0] TRAV_LD = TW'(TRAVEL_CYCLES - 1);
   localparam logic [TW-1:0] DOOR_LD = TW'(DOOR_CYCLES - 1);
   localparam logic [FW-1:0] TOP     = FW'(NUM_FLOORS - 1);
   localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);

   state_e                state_q, state_d;
   logic [FW-1:0]         floor_q, floor_d;
   logic [NUM_FLOORS-1:0] pend_q, pend_d;
   logic                  dir_q, dir_d;
   logic [1:0]            eng_q, eng_d;
   logic [NUM_FLOORS-1:0] doors_q, doors_d;

   logic                  t_load, t_hold, t_zero;
   logic [TW-1:0]         t_val;
   logic                  hold_w;

   logic [NUM_FLOORS-1:0] cur_oh, nxt_oh, clr;
   logic [NUM_FLOORS-1:0] up_mask, dn_mask;
   logic                  calls_up, calls_dn;
   logic                  at_cur, at_nxt, press_cur;

`ifdef ELEV_DOOR_HOLD_EN
   assign hold_w = door_hold;
`else
   assign hold_w = 1'b0;
`endif

   always_comb begin
      up_mask = '0;
      dn_mask = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         up_mask[i] = (i > int'(floor_q));
         dn_mask[i] = (i < int'(floor_q));
      end
   end

   assign cur_oh    = ONE << floor_q;
   assign nxt_oh    = dir_q ? (cur_oh << 1) : (cur_oh >> 1);
   assign calls_up  = |(pend_q & up_mask);
   assign calls_dn  = |(pend_q & dn_mask);
   assign at_cur    = |(pend_q & cur_oh);
   assign at_nxt    = |(pend_q & nxt_oh);
   assign press_cur = |((interior_panel | exterior_panel) & cur_oh);

   // The door-open clear beats a same-cycle press at that floor.
   assign clr    = (state_q == DOOR_OPEN) ? cur_oh : '0;
   assign pend_d = (pend_q | interior_panel | exterior_panel) & ~clr;

   elev_timer #(
      .W (TW)
   ) u_timer (
      .clk_i        (CLK),
      .rst_ni       (RST),
      .load_i       (t_load),
      .load_value_i (t_val),
      .hold_i       (t_hold),
      .zero_o       (t_zero)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         floor_q <= '0;
         pend_q  <= '0;
         dir_q   <= DIR_UP;
         eng_q   <= ENG_OFF;
         doors_q <= '0;
      end else begin
         state_q <= state_d;
         floor_q <= floor_d;
         pend_q  <= pend_d;
         dir_q   <= dir_d;
         eng_q   <= eng_d;
         doors_q <= doors_d;
      end
   end

   always_comb begin
      state_d = state_q;
      floor_d = floor_q;
      dir_d   = dir_q;
      t_load  = 1'b0;
      t_val   = TRAV_LD;
      t_hold  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (at_cur) begin
               state_d = DOOR_OPEN;
               t_load  = 1'b1;
               t_val   = DOOR_LD;
            end else if (calls_up || calls_dn) begin
               state_d = MOVING;
               t_load  = 1'b1;
               if (!(calls_up && calls_dn))
                  dir_d = calls_up ? DIR_UP : DIR_DOWN;
            end
         end
         MOVING: begin
            if (t_zero) begin
               floor_d = dir_q ? floor_q + 1'b1 : floor_q - 1'b1;
               t_load  = 1'b1;
               if (at_nxt) begin
                  state_d = DOOR_OPEN;
                  t_val   = DOOR_LD;
               end
            end
         end
         DOOR_OPEN: begin
            t_hold = hold_w;
            if (press_cur) begin
               t_load = 1'b1;
               t_val  = DOOR_LD;
            end else if (t_zero && !hold_w) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      eng_d   = ENG_OFF;
      doors_d = '0;
      unique case (state_d)
         MOVING:    eng_d   = eng_code(dir_d);
         DOOR_OPEN: doors_d = ONE << floor_d;
         default:   eng_d   = ENG_OFF;
      endcase
   end

   assign engine        = eng_q;
   assign doors         = doors_q;
   assign current_floor = floor_q;
   assign pending       = pend_q;
   assign direction     = dir_q;
   assign busy          = (state_q != IDLE);

   a_no_overrun: assert property (@(posedge CLK) disable iff (!RST)
      (state_q == MOVING && t_zero) |->
         (dir_q ? (floor_q != TOP) : (floor_q != '0)));

   a_floor_range: assert property (@(posedge CLK) disable iff (!RST)
      floor_q <= TOP);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler: expected output events are
// queued by the stimulus and checked by an independent monitor.
module tb_elevator_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] int_p = '0;
   logic [2:0] ext_p = '0;
`ifdef ELEV_DOOR_HOLD_EN
   logic       door_hold = 1'b0;
`endif

   logic [1:0] engine;
   logic [2:0] doors;
   logic [1:0] floor;
   logic [2:0] pending;
   logic       direction;
   logic       busy;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   snap_req = 0;
   logic mon_en = 1'b0;

   typedef struct {
      int         cyc;
      logic [1:0] eng;
      logic [2:0] doors;
      logic [1:0] flr;
      logic       busy;
      logic       dir;
      logic [2:0] pend;
   } ev_t;

   ev_t exq[$];

   elevator_scheduler #(
      .NUM_FLOORS    (3),
      .TRAVEL_CYCLES (8),
      .DOOR_CYCLES   (4)
   ) dut (
      .CLK            (clk),
      .RST            (rst),
`ifdef ELEV_DOOR_HOLD_EN
      .door_hold      (door_hold),
`endif
      .interior_panel (int_p),
      .exterior_panel (ext_p),
      .engine         (engine),
      .doors          (doors),
      .current_floor  (floor),
      .pending        (pending),
      .direction      (direction),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void exp_ev(int c, logic [1:0] e, logic [2:0] d,
                                  logic [1:0] f, logic b, logic dr,
                                  logic [2:0] p);
      ev_t ev;
      ev.cyc   = c;
      ev.eng   = e;
      ev.doors = d;
      ev.flr   = f;
      ev.busy  = b;
      ev.dir   = dr;
      ev.pend  = p;
      exq.push_back(ev);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [2:0] iv, input logic [2:0] xv,
                        output int t);
      t     = cyc;
      int_p = iv;
      ext_p = xv;
      tick(1);
      int_p = '0;
      ext_p = '0;
   endtask

   task automatic snap(input logic [1:0] e, input logic [2:0] d,
                       input logic [1:0] f, input logic b,
                       input logic dr, input logic [2:0] p);
      exp_ev(cyc, e, d, f, b, dr, p);
      snap_req++;
   endtask

   // Monitor: an output change (or a snapshot request) consumes one event.
   initial begin
      logic [7:0] prev;
      logic [7:0] cur;
      int         ack;
      ev_t        ex;
      prev = '0;
      ack  = 0;
      forever begin
         @(negedge clk);
         cur = {engine, doors, floor, busy};
         if (mon_en && (cur !== prev || snap_req != ack)) begin
            ack = snap_req;
            checks++;
            if (exq.size() == 0) begin
               failures++;
               $display("FAIL unexpected_event cyc=%0d eng=%b doors=%b floor=%0d busy=%b",
                        cyc, engine, doors, floor, busy);
            end else begin
               ex = exq.pop_front();
               if (cyc != ex.cyc || engine !== ex.eng ||
                   doors !== ex.doors || floor !== ex.flr ||
                   busy !== ex.busy || direction !== ex.dir ||
                   pending !== ex.pend) begin
                  failures++;
                  $display("FAIL event got cyc=%0d eng=%b doors=%b floor=%0d busy=%b dir=%b pend=%b want cyc=%0d eng=%b doors=%b floor=%0d busy=%b dir=%b pend=%b",
                           cyc, engine, doors, floor, busy, direction, pending,
                           ex.cyc, ex.eng, ex.doors, ex.flr, ex.busy,
                           ex.dir, ex.pend);
               end
            end
         end
         prev = cur;
      end
   end

   initial begin
      int t;

      // reset state
      rst = 1'b0;
      tick(3);
      mon_en = 1'b1;
      snap(2'b00, 3'b000, 2'd0, 1'b0, 1'b1, 3'b000);
      rst = 1'b1;
      tick(2);

      // hall call at the current floor: door only, no motion
      press(3'b000, 3'b001, t);
      exp_ev(t + 2, 2'b00, 3'b001, 2'd0, 1'b1, 1'b1, 3'b001);
      exp_ev(t + 6, 2'b00, 3'b000, 2'd0, 1'b0, 1'b1, 3'b000);
      tick(8);

      // floor 0 -> 2, passing floor 1 without stopping
      press(3'b100, 3'b000, t);
      exp_ev(t + 2,  2'b10, 3'b000, 2'd0, 1'b1, 1'b1, 3'b100);
      exp_ev(t + 10, 2'b10, 3'b000, 2'd1, 1'b1, 1'b1, 3'b100);
      exp_ev(t + 18, 2'b00, 3'b100, 2'd2, 1'b1, 1'b1, 3'b100);
      exp_ev(t + 22, 2'b00, 3'b000, 2'd2, 1'b0, 1'b1, 3'b000);
      tick(25);

      // door re-open at floor 2 on the 3rd door cycle
      t     = cyc;
      ext_p = 3'b100;
      tick(1);
      ext_p = '0;
      exp_ev(t + 2, 2'b00, 3'b100, 2'd2, 1'b1, 1'b1, 3'b100);
      tick(3);
      ext_p = 3'b100;
      tick(1);
      ext_p = '0;
      snap(2'b00, 3'b100, 2'd2, 1'b1, 1'b1, 3'b000);
      tick(3);
      snap(2'b00, 3'b100, 2'd2, 1'b1, 1'b1, 3'b000);
      exp_ev(t + 9, 2'b00, 3'b000, 2'd2, 1'b0, 1'b1, 3'b000);
      tick(4);

      // reset while idle at floor 2 relocates the car to floor 0
      t   = cyc;
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      exp_ev(t + 1, 2'b00, 3'b000, 2'd0, 1'b0, 1'b1, 3'b000);
      tick(3);

      // adjacent call: floor 0 -> 1
      press(3'b010, 3'b000, t);
      exp_ev(t + 2,  2'b10, 3'b000, 2'd0, 1'b1, 1'b1, 3'b010);
      exp_ev(t + 10, 2'b00, 3'b010, 2'd1, 1'b1, 1'b1, 3'b010);
      exp_ev(t + 14, 2'b00, 3'b000, 2'd1, 1'b0, 1'b1, 3'b000);
      tick(15);

      // SCAN: calls above and below from floor 1 heading up
      press(3'b101, 3'b000, t);
      exp_ev(t + 2,  2'b10, 3'b000, 2'd1, 1'b1, 1'b1, 3'b101);
      exp_ev(t + 10, 2'b00, 3'b100, 2'd2, 1'b1, 1'b1, 3'b101);
      exp_ev(t + 14, 2'b00, 3'b000, 2'd2, 1'b0, 1'b1, 3'b001);
      exp_ev(t + 15, 2'b11, 3'b000, 2'd2, 1'b1, 1'b0, 3'b001);
      exp_ev(t + 23, 2'b11, 3'b000, 2'd1, 1'b1, 1'b0, 3'b001);
      exp_ev(t + 31, 2'b00, 3'b001, 2'd0, 1'b1, 1'b0, 3'b001);
      exp_ev(t + 35, 2'b00, 3'b000, 2'd0, 1'b0, 1'b0, 3'b000);
      tick(38);

      // reset in mid-travel from floor 1 toward 2
      press(3'b100, 3'b000, t);
      exp_ev(t + 2,  2'b10, 3'b000, 2'd0, 1'b1, 1'b1, 3'b100);
      exp_ev(t + 10, 2'b10, 3'b000, 2'd1, 1'b1, 1'b1, 3'b100);
      tick(12);
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      exp_ev(t + 14, 2'b00, 3'b000, 2'd0, 1'b0, 1'b1, 3'b000);
      tick(5);

`ifdef ELEV_DOOR_HOLD_EN
      // door hold freezes the dwell for 10 cycles
      press(3'b000, 3'b001, t);
      exp_ev(t + 2, 2'b00, 3'b001, 2'd0, 1'b1, 1'b1, 3'b001);
      tick(2);
      door_hold = 1'b1;
      tick(10);
      door_hold = 1'b0;
      snap(2'b00, 3'b001, 2'd0, 1'b1, 1'b1, 3'b000);
      exp_ev(t + 16, 2'b00, 3'b000, 2'd0, 1'b0, 1'b1, 3'b000);
      tick(5);
`endif

      snap(2'b00, 3'b000, 2'd0, 1'b0, 1'b1, 3'b000);
      tick(2);

      checks++;
      if (exq.size() != 0) begin
         failures++;
         $display("FAIL missing_events left=%0d want 0", exq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
